// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer: multi-cycle instruction sequencer with a configurable
// stage count, a valid/ready instruction fetch, and an issue register.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   imem_req_valid/addr/ready fetch request handshake (addr == pc)
//   imem_resp_valid/data      fetched instruction return, latency >= 1 cycle
//   stall                     freezes execute-stage advance
//   branch_taken/target       redirect, sampled only in the last stage
//   halt                      stop once the current instruction retires
//   stage, instr, instr_valid current stage (0 = fetch) and issue register
//   pc                        address of the current instruction
//   stage_advance, retire     combinational: stage moves / instruction retires this edge
//   halted, retired_count     stopped flag and retired instruction counter
module cpu_stage_sequencer #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     NUM_STAGES = 5,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned     PC_STEP    = 1,
  parameter int unsigned     STAGE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [WIDTH-1:0]   imem_resp_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_target,
  input  logic               halt,
  output logic [STAGE_W-1:0] stage,
  output logic [WIDTH-1:0]   instr,
  output logic               instr_valid,
  output logic [WIDTH-1:0]   pc,
  output logic               stage_advance,
  output logic               retire,
  output logic               halted,
  output logic [WIDTH-1:0]   retired_count
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [WIDTH-1:0]   PC_INC     = WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    EXEC       = 2'd2,
    HALTED     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0]     instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 req_valid_q, req_valid_d;
  logic                 halted_q, halted_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      stage_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      count_q       <= '0;
      req_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      stage_q       <= stage_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      count_q       <= count_d;
      req_valid_q   <= req_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state, datapath update and combinational pulses
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stage_d       = stage_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    count_d       = count_q;
    stage_advance = 1'b0;
    retire        = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        // Handshake only counts once the registered valid is actually up,
        // so the cycle right after reset release never fires a transfer.
        if (req_valid_q && imem_req_ready) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          instr_d       = imem_resp_data;
          instr_valid_d = 1'b1;
          stage_d       = STAGE_W'(1);
          stage_advance = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          stage_advance = 1'b1;
          if (stage_q == LAST_STAGE) begin
            retire        = 1'b1;
            pc_d          = branch_taken ? branch_target : pc_q + PC_INC;
            count_d       = count_q + WIDTH'(1);
            instr_valid_d = 1'b0;
            stage_d       = '0;
            state_d       = halt ? HALTED : FETCH_REQ;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    req_valid_d = (state_d == FETCH_REQ);
    halted_d    = (state_d == HALTED);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign stage          = stage_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign retired_count  = count_q;

endmodule

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Parametrised successor to the fixed-count stage counter and issue register used by the multi-cycle core.
- Sequences a configurable number of stages per instruction.
- Fetches through a valid/ready instruction-memory handshake that tolerates variable memory latency.
- Holds the issue register, supports external stall, branch redirect and halt, and counts retired instructions. Sits between main memory control and the decoder / register file control.

Parameters:
WIDTH, 32, data/address/instruction width
NUM_STAGES, 5, stages per instruction including fetch (legal range 2..16)
RESET_PC, 0, PC value after reset
PC_STEP, 1, PC increment per sequential instruction (word addressed)
STAGE_W, 4, stage output width; must satisfy 2^STAGE_W >= NUM_STAGES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  WIDTH  fetch address (equals pc)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  fetched instruction valid
imem_resp_data  in  WIDTH  fetched instruction
stall  in  1  freeze stage advance (execute stages only)
branch_taken  in  1  redirect, sampled in last stage
branch_target  in  WIDTH  redirect address
halt  in  1  stop after the current instruction retires
stage  out  STAGE_W  current stage, 0 = fetch
instr  out  WIDTH  issue register
instr_valid  out  1  issue register holds a live instruction
pc  out  WIDTH  address of the current instruction
stage_advance  out  1  stage increments at the next edge
retire  out  1  one-cycle pulse: instruction completes this edge
halted  out  1  sequencer stopped
retired_count  out  WIDTH  retired instruction counter

Behaviour:
- Reset (rst=0, async), all outputs forced:
  - State FETCH_REQ, pc=RESET_PC, stage=0, instr=0.
  - instr_valid, halted, retire and imem_req_valid all 0; retired_count=0.
- FSM states: FETCH_REQ, FETCH_WAIT, EXEC, HALTED.
- FETCH_REQ:
  - imem_req_valid=1 from the first cycle after rst release; imem_req_addr=pc.
  - Hold valid and address stable until imem_req_ready=1, then go to FETCH_WAIT.
  - imem_resp_valid in this state is ignored, including same-cycle responses. Response latency is at least 1 cycle.
- FETCH_WAIT:
  - imem_req_valid=0; stage stays 0.
  - On imem_resp_valid=1: instr<=imem_resp_data, instr_valid<=1, stage<=1, go to EXEC.
  - Fetch latency is unbounded.
- EXEC:
  - stage increments by 1 per cycle while stall=0; stage_advance=~stall.
  - stall=1 holds stage, instr and pc unchanged.
- Last stage (stage==NUM_STAGES-1, stall=0):
  - retire=1.
  - pc<=branch_taken ? branch_target : pc+PC_STEP (modulo 2^WIDTH).
  - retired_count<=retired_count+1 (wraps at 2^WIDTH).
  - instr_valid<=0, stage<=0.
  - Next state is HALTED if halt=1, else FETCH_REQ.
- branch_taken/halt outside the last stage, or while stalled, are ignored.
- stall is ignored in FETCH_REQ and FETCH_WAIT.
- HALTED:
  - halted=1, no requests issued, all state frozen.
  - Exit only via reset.
- Stray imem_resp_valid in EXEC or HALTED is ignored.
- Reset mid-operation:
  - Any in-flight fetch is abandoned.
  - The memory side is reset by the same rst; a response arriving after reset release while in FETCH_REQ is discarded.
- NUM_STAGES=2: one EXEC cycle; stage 1 is the last stage.
- Minimum cycles per instruction: 1 (request) + 1 (response) + NUM_STAGES-1.

Test Plan:
- Reset then zero-wait memory (ready=1, resp 1 cycle later), NUM_STAGES=5, 3 instructions:
  - imem_req_addr sequence 0,1,2.
  - retire pulses 6 cycles apart.
  - retired_count=3.
- imem_req_ready low for 4 cycles, then response delayed 3 cycles:
  - req_valid and addr=0 held stable throughout.
  - stage stays 0.
  - instr loads exactly on the resp_valid cycle.
- stall=1 for 2 cycles at stage 2:
  - stage reads 2,2,2,3.
  - stage_advance=0 during stall.
  - instruction retires 2 cycles later than the unstalled case.
- branch_taken=1, branch_target=0x40 at stage 4 with pc=0x10:
  - next imem_req_addr=0x40.
  - branch_taken asserted at stage 2 only: next addr=0x11.
- halt=1 at the last stage of instruction at pc=7:
  - retire pulses, halted=1, pc=8.
  - imem_req_valid stays 0 for 20 further cycles.
- rst low in FETCH_WAIT at pc=0x22:
  - all outputs at reset values immediately (async).
  - stale resp_valid after release is ignored.
  - first request is addr=RESET_PC.
